// File: rtl/axi_pkg.sv
// Shared AXI4 field types and encodings used by the burst master,
// its W holding register and the bus interface.
package axi_pkg;
    typedef logic [31:0] addr_t;
    typedef logic [7:0]  len_t;
    typedef logic [2:0]  size_t;
    typedef logic [1:0]  burst_t;
    typedef logic [31:0] data_t;
    typedef logic [1:0]  resp_t;
    typedef logic [3:0]  strb_t;

    localparam resp_t  RESP_OKAY   = 2'b00;
    localparam resp_t  RESP_SLVERR = 2'b10;
    localparam burst_t BURST_FIXED = 2'b00;
    localparam burst_t BURST_INCR  = 2'b01;
    localparam strb_t  STRB_ALL    = 4'hF;
endpackage

// File: rtl/axi_if.sv
// AXI4 bus bundle (no IDs/cache/prot). Every channel transfers on a rising aclk edge where
// valid and ready are both high; valid, once raised, holds with stable payload until that edge.
interface axi_if;
    import axi_pkg::*;

    addr_t  awaddr;
    len_t   awlen;
    size_t  awsize;
    burst_t awburst;
    logic   awvalid;
    logic   awready;

    data_t  wdata;
    strb_t  wstrb;
    logic   wlast;
    logic   wvalid;
    logic   wready;

    resp_t  bresp;
    logic   bvalid;
    logic   bready;

    addr_t  araddr;
    len_t   arlen;
    size_t  arsize;
    burst_t arburst;
    logic   arvalid;
    logic   arready;

    data_t  rdata;
    resp_t  rresp;
    logic   rlast;
    logic   rvalid;
    logic   rready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arlen, arsize, arburst, arvalid, input arready,
        input rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input awaddr, awlen, awsize, awburst, awvalid, output awready,
        input wdata, wstrb, wlast, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arlen, arsize, arburst, arvalid, output arready,
        output rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/axi_reg_slice.sv
// One-entry valid/ready holding register; out_valid comes straight from a flop,
// and a full entry can be replaced in the same cycle it drains.
module axi_reg_slice
    import axi_pkg::*;
(
    input  logic  aclk,
    input  logic  areset_n,
    input  logic  in_valid,
    output logic  in_ready,
    input  data_t in_data,
    output logic  out_valid,
    input  logic  out_ready,
    output data_t out_data
);
    logic  full_q;
    data_t data_q;

    assign in_ready  = !full_q || out_ready;
    assign out_valid = full_q;
    assign out_data  = data_q;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (in_valid && in_ready) begin
            full_q <= 1'b1;
            data_q <= in_data;
        end else if (out_ready) begin
            full_q <= 1'b0;
        end
    end
endmodule

// File: rtl/axi_burst_master.sv
// Command-driven AXI4 burst master: one read (AR, R beats) or write (AW, W beats, B)
// outstanding at a time, with one done pulse per command.
module axi_burst_master
    import axi_pkg::*;
(
    input  logic         aclk,
    input  logic         areset_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_write,
    input  addr_t        cmd_addr,
    input  len_t         cmd_len,
    input  size_t        cmd_size,
    input  burst_t       cmd_burst,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  data_t        wr_data,
    output logic         rd_valid,
    input  logic         rd_ready,
    output data_t        rd_data,
    output logic         rd_last,
    output logic         done,
    output resp_t        done_resp,
    output logic [2:0]   dbg_state,
    axi_if.master        m_axi
);
    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE} state_e;

    state_e state_q, state_d;
    addr_t  addr_q;
    len_t   len_q;
    size_t  size_q;
    burst_t burst_q;
    len_t   cnt_q;
    len_t   in_cnt_q;
    logic   in_all_q;
    logic   err_q;
    resp_t  resp_q;

    logic   cmd_hs, ar_hs, r_hs, aw_hs, w_hs, b_hs, at_last;
    logic   slice_in_valid, slice_in_ready, slice_out_valid;
    data_t  slice_out_data;

    assign cmd_ready = (state_q == S_IDLE);
    assign cmd_hs    = cmd_valid && cmd_ready;
    assign at_last   = (cnt_q == len_q);
    assign ar_hs     = m_axi.arvalid && m_axi.arready;
    assign r_hs      = m_axi.rvalid && m_axi.rready;
    assign aw_hs     = m_axi.awvalid && m_axi.awready;
    assign w_hs      = m_axi.wvalid && m_axi.wready;
    assign b_hs      = m_axi.bvalid && m_axi.bready;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_hs) state_d = cmd_write ? S_AW : S_AR;
            S_AR:    if (ar_hs) state_d = S_R;
            S_R:     if (r_hs && at_last) state_d = S_DONE;
            S_AW:    if (aw_hs) state_d = S_W;
            S_W:     if (w_hs && at_last) state_d = S_B;
            S_B:     if (b_hs) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // cnt_q counts bus beats; in_cnt_q/in_all_q stop the client once len+1 beats are taken.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            cnt_q    <= '0;
            in_cnt_q <= '0;
            in_all_q <= 1'b0;
            err_q    <= 1'b0;
            resp_q   <= RESP_OKAY;
        end else begin
            if (cmd_hs) begin
                addr_q   <= cmd_addr;
                len_q    <= cmd_len;
                size_q   <= cmd_size;
                burst_q  <= cmd_burst;
                cnt_q    <= '0;
                in_cnt_q <= '0;
                in_all_q <= 1'b0;
                err_q    <= 1'b0;
                resp_q   <= RESP_OKAY;
            end
            if ((r_hs || w_hs) && !at_last) cnt_q <= cnt_q + 8'd1;
            if (r_hs) begin
                if (m_axi.rlast != at_last) begin
                    err_q  <= 1'b1;
                    resp_q <= RESP_SLVERR;
                end else if (m_axi.rresp != RESP_OKAY) begin
                    err_q  <= 1'b1;
                    resp_q <= m_axi.rresp;
                end
            end
            if (slice_in_valid) begin
                if (in_cnt_q == len_q) in_all_q <= 1'b1;
                else                   in_cnt_q <= in_cnt_q + 8'd1;
            end
            if (b_hs) begin
                resp_q <= m_axi.bresp;
                err_q  <= (m_axi.bresp != RESP_OKAY);
            end
        end
    end

    assign wr_ready       = (state_q == S_W) && !in_all_q && slice_in_ready;
    assign slice_in_valid = wr_valid && wr_ready;

    axi_reg_slice u_w_slice (
        .aclk      (aclk),
        .areset_n  (areset_n),
        .in_valid  (slice_in_valid),
        .in_ready  (slice_in_ready),
        .in_data   (wr_data),
        .out_valid (slice_out_valid),
        .out_ready (m_axi.wready),
        .out_data  (slice_out_data)
    );

    assign m_axi.awaddr  = addr_q;
    assign m_axi.awlen   = len_q;
    assign m_axi.awsize  = size_q;
    assign m_axi.awburst = burst_q;
    assign m_axi.awvalid = (state_q == S_AW);
    assign m_axi.wdata   = slice_out_data;
    assign m_axi.wstrb   = STRB_ALL;
    assign m_axi.wlast   = at_last;
    assign m_axi.wvalid  = slice_out_valid;
    assign m_axi.bready  = (state_q == S_B);
    assign m_axi.araddr  = addr_q;
    assign m_axi.arlen   = len_q;
    assign m_axi.arsize  = size_q;
    assign m_axi.arburst = burst_q;
    assign m_axi.arvalid = (state_q == S_AR);
    assign m_axi.rready  = (state_q == S_R) && rd_ready;

    assign rd_valid  = (state_q == S_R) && m_axi.rvalid;
    assign rd_data   = (state_q == S_R) ? m_axi.rdata : '0;
    assign rd_last   = (state_q == S_R) && at_last;
    assign done      = (state_q == S_DONE);
    assign done_resp = err_q ? resp_q : RESP_OKAY;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: client driver tasks, a small AXI slave model with
// stall/error knobs, and write/read expected-data queues checked as beats appear.
`timescale 1ns/1ps
module tb_axi_burst_master;
    import axi_pkg::*;

    logic       aclk;
    logic       areset_n;
    logic       cmd_valid, cmd_ready, cmd_write;
    addr_t      cmd_addr;
    len_t       cmd_len;
    size_t      cmd_size;
    burst_t     cmd_burst;
    logic       wr_valid, wr_ready;
    data_t      wr_data;
    logic       rd_valid, rd_ready, rd_last;
    data_t      rd_data;
    logic       done;
    resp_t      done_resp;
    logic [2:0] dbg_state;

    axi_if m_axi ();

    axi_burst_master dut (
        .aclk      (aclk),
        .areset_n  (areset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_size  (cmd_size),
        .cmd_burst (cmd_burst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .done      (done),
        .done_resp (done_resp),
        .dbg_state (dbg_state),
        .m_axi     (m_axi)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt = 0;

    logic [31:0] w_exp_q[$];
    logic [31:0] r_exp_q[$];
    logic [31:0] ref_mem [0:63];
    logic [31:0] s_mem   [0:63];

    // slave knobs
    int ar_stall = 0;
    bit b_err = 0;
    int rlast_early = -1;
    bit w_rand = 0;
    bit w_sustain = 0;
    addr_t exp_araddr = '0;

    // slave state
    bit    r_act, b_pend;
    addr_t r_addr, w_addr;
    int    r_len, r_beat, w_len, w_beat, ar_wait;
    int    b_cyc, r_last_cyc, w_prev_cyc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int idx(input addr_t a, input int b);
        return (int'(a[7:2]) + b) % 64;
    endfunction

    // clock / reset / bookkeeping
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end
    initial forever begin
        @(posedge aclk);
        cyc++;
    end
    initial forever begin
        @(negedge aclk);
        if (done === 1'b1) done_cnt++;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic slave_clear();
        r_act = 0; b_pend = 0; ar_wait = 0;
        r_beat = 0; r_len = 0; w_beat = 0; w_len = 0;
        r_addr = '0; w_addr = '0;
    endtask

    task automatic slave_drive_idle();
        m_axi.arready = 1'b0; m_axi.awready = 1'b0; m_axi.wready = 1'b0;
        m_axi.rvalid = 1'b0; m_axi.rdata = '0; m_axi.rresp = RESP_OKAY; m_axi.rlast = 1'b0;
        m_axi.bvalid = 1'b0; m_axi.bresp = RESP_OKAY;
    endtask

    // AXI slave model: observe at negedge (handshakes happen at the next posedge), drive at posedge+1
    initial begin
        logic [31:0] e;
        slave_clear();
        slave_drive_idle();
        foreach (s_mem[i]) s_mem[i] = '0;
        forever begin
            @(negedge aclk);
            if (!areset_n) begin
                slave_clear();
            end else begin
                if (m_axi.arvalid && m_axi.arready) begin
                    check_eq("ar_stall_held", ar_wait, ar_stall);
                    check_eq("araddr", m_axi.araddr, exp_araddr);
                    r_act = 1; r_addr = m_axi.araddr; r_len = int'(m_axi.arlen); r_beat = 0; ar_wait = 0;
                end else if (m_axi.arvalid) begin
                    ar_wait++;
                end
                if (m_axi.rvalid && m_axi.rready) begin
                    if (r_beat == r_len) begin
                        r_act = 0;
                        r_last_cyc = cyc;
                    end
                    r_beat++;
                end
                if (m_axi.awvalid && m_axi.awready) begin
                    w_addr = m_axi.awaddr; w_len = int'(m_axi.awlen); w_beat = 0;
                end
                if (m_axi.wvalid && m_axi.wready) begin
                    e = (w_exp_q.size() != 0) ? w_exp_q.pop_front() : 32'hDEAD_BEEF;
                    check_eq("wdata", m_axi.wdata, e);
                    check_eq("wlast", m_axi.wlast, (w_beat == w_len));
                    check_eq("wstrb", m_axi.wstrb, 4'hF);
                    if (w_sustain && w_beat > 0) check_eq("w_rate", cyc - w_prev_cyc, 1);
                    w_prev_cyc = cyc;
                    s_mem[idx(w_addr, w_beat)] = m_axi.wdata;
                    if (w_beat == w_len) b_pend = 1;
                    w_beat++;
                end
                if (m_axi.bvalid && m_axi.bready) begin
                    b_pend = 0;
                    b_cyc = cyc;
                end
            end
            @(posedge aclk);
            #1;
            if (!areset_n) begin
                slave_drive_idle();
            end else begin
                m_axi.arready = m_axi.arvalid && (ar_wait >= ar_stall);
                m_axi.rvalid  = r_act;
                m_axi.rdata   = r_act ? s_mem[idx(r_addr, r_beat)] : '0;
                m_axi.rlast   = r_act && ((r_beat == r_len) || (r_beat == rlast_early));
                m_axi.rresp   = RESP_OKAY;
                m_axi.awready = m_axi.awvalid;
                m_axi.wready  = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                m_axi.bvalid  = b_pend;
                m_axi.bresp   = b_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // client driver tasks
    task automatic send_cmd(input bit wr, input addr_t a, input len_t l);
        bit got = 0;
        @(posedge aclk); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
        cmd_size = 3'd2; cmd_burst = BURST_INCR;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge aclk);
            if (cmd_ready) got = 1;
            else begin @(posedge aclk); #1; end
        end
        check_eq("cmd_accept", got, 1);
        @(posedge aclk); #1;
        cmd_valid = 1'b0;
        @(negedge aclk);
        if (wr) begin
            check_eq("aw_latency", m_axi.awvalid, 1);
            check_eq("awaddr", m_axi.awaddr, a);
            check_eq("awlen", m_axi.awlen, l);
        end else begin
            check_eq("ar_latency", m_axi.arvalid, 1);
            check_eq("arlen", m_axi.arlen, l);
        end
    endtask

    task automatic wait_wr_ready();
        bit got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge aclk);
            if (wr_ready) got = 1;
            else begin @(posedge aclk); #1; end
        end
        check_eq("wr_accept", got, 1);
    endtask

    task automatic wait_done(input resp_t exp, input bit is_wr);
        bit got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge aclk);
            if (done) got = 1;
        end
        check_eq("done_seen", got, 1);
        check_eq("done_resp", done_resp, exp);
        check_eq("done_latency", cyc, (is_wr ? b_cyc : r_last_cyc) + 1);
        @(negedge aclk);
        check_eq("done_pulse", done, 0);
        check_eq("idle_ready", cmd_ready, 1);
    endtask

    task automatic do_write(input addr_t a, input len_t l, input bit rnd, input resp_t exp);
        data_t d;
        send_cmd(1'b1, a, l);
        for (int b = 0; b <= int'(l); b++) begin
            d = rnd ? $urandom : (32'hA0 + 32'(b));
            w_exp_q.push_back(d);
            ref_mem[idx(a, b)] = d;
            @(posedge aclk); #1;
            wr_valid = 1'b1; wr_data = d;
            wait_wr_ready();
        end
        @(posedge aclk); #1;
        wr_valid = 1'b0;
        wait_done(exp, 1'b1);
        check_eq("w_exp_empty", w_exp_q.size(), 0);
    endtask

    task automatic do_read(input addr_t a, input len_t l, input bit toggle, input resp_t exp);
        int beats = 0;
        int k = 0;
        logic [3:0] pat = 4'b1001;
        logic [31:0] e;
        for (int b = 0; b <= int'(l); b++) r_exp_q.push_back(ref_mem[idx(a, b)]);
        exp_araddr = a;
        send_cmd(1'b0, a, l);
        for (int i = 0; i < 300 && beats <= int'(l); i++) begin
            @(posedge aclk); #1;
            rd_ready = toggle ? pat[k % 4] : 1'b1;
            k++;
            @(negedge aclk);
            if (m_axi.rvalid) check_eq("rready_mirror", m_axi.rready, rd_ready);
            if (rd_valid && rd_ready) begin
                e = (r_exp_q.size() != 0) ? r_exp_q.pop_front() : 32'hDEAD_BEEF;
                check_eq("rd_data", rd_data, e);
                check_eq("rd_last", rd_last, (beats == int'(l)));
                beats++;
            end
        end
        check_eq("rd_beats", beats, int'(l) + 1);
        @(posedge aclk); #1;
        rd_ready = 1'b0;
        wait_done(exp, 1'b0);
    endtask

    task automatic check_quiet(input string tag);
        check_eq(tag, {m_axi.arvalid, m_axi.awvalid, m_axi.wvalid, m_axi.rready,
                       m_axi.bready, wr_ready, rd_valid, done}, 0);
    endtask

    // main sequence
    initial begin
        int done_base;
        data_t d;
        foreach (ref_mem[i]) ref_mem[i] = '0;
        areset_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        cmd_size = '0; cmd_burst = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;

        repeat (3) @(negedge aclk);
        check_quiet("rst_valids");
        check_eq("rst_addr", m_axi.awaddr, 0);
        areset_n = 1'b1;
        @(negedge aclk);
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_quiet("post_rst_quiet");

        w_sustain = 1;
        do_write(32'h0, 8'd3, 1'b0, RESP_OKAY);
        w_sustain = 0;
        do_read(32'h0, 8'd3, 1'b0, RESP_OKAY);

        ar_stall = 3;
        do_read(32'h0, 8'd3, 1'b1, RESP_OKAY);
        ar_stall = 0;

        b_err = 1;
        do_write(32'h20, 8'd1, 1'b1, RESP_SLVERR);
        b_err = 0;

        rlast_early = 1;
        do_read(32'h0, 8'd3, 1'b0, RESP_SLVERR);
        rlast_early = -1;

        do_write(32'h40, 8'd0, 1'b1, RESP_OKAY);
        do_read(32'h40, 8'd0, 1'b0, RESP_OKAY);

        w_rand = 1;
        do_write(32'h60, 8'd5, 1'b1, RESP_OKAY);
        ar_stall = $urandom_range(0, 2);
        do_read(32'h60, 8'd5, 1'b1, RESP_OKAY);
        ar_stall = 0;

        // abandon a write burst part-way through
        done_base = done_cnt;
        send_cmd(1'b1, 32'h80, 8'd7);
        for (int b = 0; b < 3; b++) begin
            d = $urandom;
            w_exp_q.push_back(d);
            @(posedge aclk); #1;
            wr_valid = 1'b1; wr_data = d;
            wait_wr_ready();
        end
        @(posedge aclk); #3;
        areset_n = 1'b0;
        wr_valid = 1'b0;
        @(negedge aclk);
        check_quiet("midw_rst_valids");
        check_eq("midw_rst_state", dbg_state, 0);
        @(negedge aclk);
        w_exp_q.delete();
        areset_n = 1'b1;
        @(negedge aclk);
        check_eq("midw_cmd_ready", cmd_ready, 1);
        check_quiet("midw_post_quiet");
        repeat (10) @(negedge aclk);
        check_eq("midw_no_done", done_cnt, done_base);
        w_rand = 0;

        do_read(32'h0, 8'd3, 1'b0, RESP_OKAY);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/axi_burst_master.md
# axi_burst_master

Command-driven AXI4 burst master sitting directly upstream of the team's AXI4 slave: a local client issues one read or write command at a time, and the block runs the full AXI4 handshake sequence. Read sequence: AR, R beats. Write sequence: AW, W beats, B. It streams write data in from the client, streams read data out, and reports one completion per command. One transaction is outstanding at a time; no read/write overlap.

## Interface
- Parameters: none; all widths come from `axi_pkg` (`addr_t` 32, `len_t` 8, `size_t` 3, `burst_t` 2, `data_t` 32, `resp_t` 2).
- `aclk`  in  1  single clock; all logic is rising-edge.
- `areset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when both high.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  addr_t  start address.
- `cmd_len`  in  len_t  beats − 1.
- `cmd_size`  in  size_t  AxSIZE.
- `cmd_burst`  in  burst_t  AxBURST.
- `wr_valid`  in  1  write-data beat offered.
- `wr_ready`  out  1  write-data beat accepted.
- `wr_data`  in  data_t  write-data beat.
- `rd_valid`  out  1  read beat available.
- `rd_ready`  in  1  client accepts read beat.
- `rd_data`  out  data_t  read beat.
- `rd_last`  out  1  final beat of the command.
- `done`  out  1  one-cycle completion pulse.
- `done_resp`  out  resp_t  completion status; valid with `done`.
- `m_axi`  axi_if.master  full AXI4 master port.

## Operation
- States: IDLE, AR, R, AW, W, B, DONE.
- IDLE:
  - `cmd_ready` = 1.
  - On command handshake, latch addr/len/size/burst/write, clear beat counter and error flag.
  - Go to AW if the command is a write, otherwise AR.
- AR:
  - `arvalid` = 1 with latched fields, held stable until `arready`.
  - On handshake go to R.
- R:
  - `rready` = `rd_ready`; `rd_valid` = `rvalid`; `rd_data` = `rdata`.
  - Each R handshake increments the beat counter.
  - Any `rresp` != OKAY sets the error flag.
  - `rd_last` is high on the beat where counter == len.
  - `rlast` mismatch sets the error flag: `rlast` = 0 on beat len, or `rlast` = 1 before beat len.
  - The burst always ends after exactly len+1 beats; then go to DONE.
- AW:
  - `awvalid` = 1 held stable until `awready`; on handshake go to W.
- W:
  - W path is a 1-entry holding register.
  - `wr_ready` = 1 when the register is empty, or is being drained this cycle.
  - `wvalid` = register full; `wlast` = (counter == len).
  - `wstrb` all ones.
  - After the W handshake with `wlast` = 1, go to B.
- B:
  - `bready` = 1; on handshake capture `bresp`; go to DONE.
- DONE:
  - `done` = 1 for one cycle.
  - `done_resp`: OKAY if no error; otherwise the last non-OKAY response, or SLVERR (2'b10) for a `rlast` mismatch.
  - Return to IDLE.
- Beat counter is 8 bits and never wraps: max len 255 gives 256 beats, and the counter stops at len.
- `wr_valid` while not in W: not accepted (`wr_ready` = 0).
- `cmd_valid` outside IDLE: ignored.

## Timing
- Reset (async assert, sync deassert via `aclk`):
  - state = IDLE.
  - All AXI valid/ready outputs = 0.
  - `wr_ready`, `rd_valid`, `done` = 0; `cmd_ready` = 1 after reset.
  - Address/data outputs = 0.
- Reset mid-transaction: the transaction is abandoned; no `done`; the holding register is emptied.
- All AXI `*valid` outputs are registered and never depend combinationally on the matching `*ready`.
- Read latency: command handshake at cycle N → `arvalid` at N+1.
- Read completion: last R beat at cycle M → `done` at M+1 → `cmd_ready` at M+2.
- Write latency: command handshake at N → `awvalid` at N+1.
- W throughput: first W beat no earlier than the cycle after the AW handshake; one beat per cycle sustained when `wr_valid` and `wready` stay high.
- Write completion: B handshake at M → `done` at M+1.

## Structure
- Shared types (`axi_pkg`): `addr_t`, `len_t`, `size_t`, `burst_t`, `data_t`, `resp_t`, `RESP_OKAY`/`RESP_SLVERR`, `BURST_FIXED`/`BURST_INCR`.
- The state enum stays local to the module.
- One sub-module is natural: `axi_reg_slice`, a 1-entry valid/ready register used for the W holding path.

## Test plan
- Reset check: reset asserted at an arbitrary time, including mid-W burst → all valids 0, `cmd_ready` = 1 after release, no `done`.
- Write: INCR, addr 0, len 3, data 0xA0..0xA3 → four W beats in order, `wlast` on 0xA3 only, `done` with OKAY one cycle after B.
- Read-back: read addr 0, len 3 → `rd_data` 0xA0..0xA3, `rd_last` on the fourth beat, `done_resp` OKAY.
- Backpressure: read with `rd_ready` toggling 1,0,0,1 → `rready` mirrors it, no beat lost or duplicated; `arvalid` held through a 3-cycle `arready` stall.
- Errors:
  - Slave returns `bresp` SLVERR → `done_resp` 2'b10.
  - Slave raises `rlast` on beat 1 of a len=3 read → 4 beats still taken, `done_resp` 2'b10.
- Single beat: len = 0 read and write → exactly one beat each, `wlast`/`rd_last` on beat 0.
